// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer and counter debouncer with a registered press strobe.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce #(
  parameter int KEYBITS         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNTBITS         = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEYBITS-1:0] KEY_IN,
  output logic [KEYBITS-1:0] KEY_OUT,
  output logic [KEYBITS-1:0] KEY_PRESS
);

  localparam logic [CNTBITS-1:0] DB_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);
  localparam longint CNT_LIMIT = longint'(1) << CNTBITS;

  // A bad parameter set elaborates this block and is easy to spot.
  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) >= CNT_LIMIT ||
      longint'(REPEAT_DELAY) >= CNT_LIMIT ||
      longint'(REPEAT_PERIOD) >= CNT_LIMIT) begin : g_bad_cfg
    localparam int CFG_ERROR = 1;
  end

  logic [KEYBITS-1:0] sync1;
  logic [KEYBITS-1:0] sync2;
  logic [KEYBITS-1:0] stable;
  logic [KEYBITS-1:0] accept;
  logic [KEYBITS-1:0] stable_nxt;
  logic [CNTBITS-1:0] cnt [KEYBITS];

  always_comb begin
    accept = '0;
    for (int i = 0; i < KEYBITS; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == DB_LAST);
    end
    stable_nxt = (stable & ~accept) | (sync2 & accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < KEYBITS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= KEY_IN;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int i = 0; i < KEYBITS; i++) begin
        if (sync2[i] == stable[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNTBITS'(1);
        end
      end
    end
  end

`ifndef KEY_AUTOREPEAT_EN

  assign KEY_OUT = stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      KEY_PRESS <= '0;
    end else begin
      KEY_PRESS <= accept & ~sync2;
    end
  end

`else

  localparam logic [CNTBITS-1:0] RD_LAST = CNTBITS'(REPEAT_DELAY - 1);
  localparam logic [CNTBITS-1:0] RP_LAST = CNTBITS'(REPEAT_PERIOD - 1);

  logic [CNTBITS-1:0] rcnt [KEYBITS];
  logic [KEYBITS-1:0] rep;
  logic [KEYBITS-1:0] blip;
  logic [KEYBITS-1:0] hit;
  logic [KEYBITS-1:0] blip_nxt;

  // A release accepted on a repeat edge suppresses that repeat.
  always_comb begin
    hit      = '0;
    blip_nxt = '0;
    for (int i = 0; i < KEYBITS; i++) begin
      hit[i]      = rep[i] ? (rcnt[i] == RP_LAST) : (rcnt[i] == RD_LAST);
      blip_nxt[i] = ~stable[i] & hit[i] & ~accept[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep       <= '0;
      blip      <= '0;
      KEY_OUT   <= '1;
      KEY_PRESS <= '0;
      for (int i = 0; i < KEYBITS; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEYBITS; i++) begin
        if (stable[i]) begin
          rcnt[i] <= '0;
          rep[i]  <= 1'b0;
        end else if (hit[i]) begin
          rcnt[i] <= '0;
          rep[i]  <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + CNTBITS'(1);
        end
      end
      blip      <= blip_nxt;
      KEY_OUT   <= stable_nxt | blip_nxt;
      KEY_PRESS <= (accept & ~sync2) | (blip & ~stable_nxt);
    end
  end

`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a sliding-window reference model.
module tb_key_debounce;

  localparam int K  = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 10;

`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_REPS = 4;
  localparam logic EXP_HI20 = 1'b1;
`else
  localparam int EXP_REPS = 0;
  localparam logic EXP_HI20 = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [K-1:0] key_in;
  logic [K-1:0] key_out;
  logic [K-1:0] key_press;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  int press_cnt [K] = '{0, 0, 0, 0};

  key_debounce #(
    .KEYBITS(K),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNTBITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY_IN(key_in),
    .KEY_OUT(key_out),
    .KEY_PRESS(key_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level is accepted once D consecutive samples, ending two
  // edges ago, all differ from the current level; repeats by age.
  logic [K-1:0] win [D+2];
  logic [K-1:0] m_stable;
  logic [K-1:0] m_blip;
  logic [K-1:0] m_out;
  logic [K-1:0] m_press;
  int           m_age [K];

  always @(posedge clk) begin : model
    logic [K-1:0] w [D+2];
    logic [K-1:0] st;
    logic [K-1:0] bl;
    logic [K-1:0] pr;
    int           ag [K];
    logic         run;
    if (reset) begin
      for (int j = 0; j < D + 2; j++) win[j] <= '1;
      m_stable <= '1;
      m_blip   <= '0;
      m_out    <= '1;
      m_press  <= '0;
      for (int i = 0; i < K; i++) m_age[i] <= 0;
    end else begin
      w[0] = key_in;
      for (int j = 1; j < D + 2; j++) w[j] = win[j-1];
      st = m_stable;
      bl = '0;
      pr = '0;
      for (int i = 0; i < K; i++) begin
        ag[i] = m_age[i];
        run = 1'b1;
        for (int j = 2; j < D + 2; j++) begin
          if (w[j][i] == m_stable[i]) run = 1'b0;
        end
        if (run) st[i] = ~m_stable[i];
        if (m_stable[i] && !st[i]) begin
          pr[i] = 1'b1;
          ag[i] = 0;
        end else if (!st[i]) begin
`ifdef KEY_AUTOREPEAT_EN
          if (m_blip[i]) pr[i] = 1'b1;
          ag[i] = ag[i] + 1;
          bl[i] = (ag[i] >= RD) && (((ag[i] - RD) % RP) == 0);
`endif
        end else begin
          ag[i] = 0;
        end
      end
      for (int j = 0; j < D + 2; j++) win[j] <= w[j];
      for (int i = 0; i < K; i++) m_age[i] <= ag[i];
      m_stable <= st;
      m_blip   <= bl;
      m_out    <= st | bl;
      m_press  <= pr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (key_out !== m_out || key_press !== m_press) begin
        failures++;
        $display("FAIL model t=%0t out=%h want %h press=%h want %h",
                 $time, key_out, m_out, key_press, m_press);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (key_press[i] === 1'b1) press_cnt[i]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int lows;
    int p;
    int reps;
    int pulses;
    logic hi20;
    logic pr21;

    reset  = 1'b1;
    key_in = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out", 32'(key_out), 32'hF);
    chk("rst_press", 32'(key_press), 32'h0);

    // key held low through reset
    @(negedge clk) reset = 1'b0;
    step(9);
    chk("t1_e9_out", 32'(key_out), 32'hF);
    step(1);
    chk("t1_e10_out", 32'(key_out), 32'h0);
    chk("t1_e10_press", 32'(key_press), 32'hF);
    step(1);
    chk("t1_e11_press", 32'(key_press), 32'h0);
    @(negedge clk) key_in = '1;
    step(12);

    // clean press and release
    @(negedge clk) key_in[0] = 1'b0;
    step(9);
    chk("t2_e9_out", 32'(key_out), 32'hF);
    step(1);
    chk("t2_e10_out", 32'(key_out), 32'hE);
    chk("t2_e10_press", 32'(key_press), 32'h1);
    step(1);
    chk("t2_e11_press", 32'(key_press), 32'h0);
    @(negedge clk) key_in[0] = 1'b1;
    step(9);
    chk("t2_rel_e9", 32'(key_out), 32'hE);
    step(1);
    chk("t2_rel_e10", 32'(key_out), 32'hF);
    chk("t2_rel_press", 32'(key_press), 32'h0);
    step(3);

    // bounce on bit 1
    p = press_cnt[1];
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk) key_in[1] = ((k / 3) % 2) == 1;
      @(posedge clk);
      #1;
      if (!key_out[1]) lows++;
    end
    chk("t3_bounce_lows", 32'(lows), 32'h0);
    @(negedge clk) key_in[1] = 1'b0;
    step(9);
    chk("t3_e9_out", 32'(key_out), 32'hF);
    step(1);
    chk("t3_e10_out", 32'(key_out), 32'hD);
    chk("t3_e10_press", 32'(key_press), 32'h2);
    step(1);
    chk("t3_strobes", 32'(press_cnt[1] - p), 32'h1);
    @(negedge clk) key_in[1] = 1'b1;
    step(12);

    // 7-cycle glitch on bit 2
    p = press_cnt[2];
    @(negedge clk) key_in[2] = 1'b0;
    repeat (7) @(negedge clk);
    key_in[2] = 1'b1;
    step(15);
    chk("t4_out", 32'(key_out), 32'hF);
    chk("t4_strobes", 32'(press_cnt[2] - p), 32'h0);

    // simultaneous bits 3 and 0, then bit 0 bounces and releases
    @(negedge clk) key_in = 4'b0110;
    step(9);
    chk("t5_e9_out", 32'(key_out), 32'hF);
    step(1);
    chk("t5_e10_out", 32'(key_out), 32'h6);
    chk("t5_e10_press", 32'(key_press), 32'h9);
    step(1);
    chk("t5_e11_press", 32'(key_press), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) key_in[0] = (k % 2) == 0;
    end
    @(negedge clk) key_in = 4'b0111;
    step(10);
    chk("t5_bit0_rel", 32'(key_out), 32'h7);
    @(negedge clk) key_in = '1;
    step(25);

    // long hold on bit 0
    @(negedge clk) key_in[0] = 1'b0;
    step(10);
    chk("t6_accept", 32'(key_out), 32'hE);
    reps = 0;
    pulses = 0;
    hi20 = 1'b0;
    pr21 = 1'b0;
    for (int k = 1; k < 60; k++) begin
      step(1);
      if (key_out[0]) reps++;
      if (key_press[0]) pulses++;
      if (k == 20) hi20 = key_out[0];
      if (k == 21) pr21 = key_press[0];
    end
    chk("t6_blips", 32'(reps), 32'(EXP_REPS));
    chk("t6_pulses", 32'(pulses), 32'(EXP_REPS));
    chk("t6_hi_at_20", 32'(hi20), 32'(EXP_HI20));
    chk("t6_press_at_21", 32'(pr21), 32'(EXP_HI20));
    @(negedge clk) key_in = '1;
    step(25);
    chk("end_out", 32'(key_out), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
